// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bundle layout and ALU operation encodings used by
// decode, EX and writeback.
package cpu_pkg;

  localparam int unsigned CTRL_W = 8;

  // Bit positions inside the control bundle.
  localparam int unsigned CTRL_REG_WRITE = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_MEM_READ = 5;
  localparam int unsigned CTRL_MEM_WRITE = 4;
  localparam int unsigned CTRL_ALU_SRC = 3;
  localparam int unsigned CTRL_REG_DST = 2;
  localparam int unsigned CTRL_ALU_OP_MSB = 1;
  localparam int unsigned CTRL_ALU_OP_LSB = 0;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10,
    AluOr    = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  // An instruction reads rt when the ALU takes it as operand B or when it is a store.
  function automatic logic ctrl_uses_rt(input logic alu_src, input logic mem_write);
    return !alu_src || mem_write;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the instruction in EX and the one in decode.
// Purely combinational.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH_ADD = 5
) (
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [WIDTH_ADD-1:0] ex_dest,
  input  logic                 id_valid,
  input  logic                 id_alu_src,
  input  logic                 id_mem_write,
  input  logic [WIDTH_ADD-1:0] rs_add,
  input  logic [WIDTH_ADD-1:0] rt_add,
  input  logic                 ex_flush,
  output logic                 hazard,
  output logic                 stall
);

  logic uses_rt;
  logic rs_match;
  logic rt_match;

  always_comb begin
    uses_rt  = ctrl_uses_rt(id_alu_src, id_mem_write);
    rs_match = (ex_dest == rs_add);
    rt_match = uses_rt && (ex_dest == rt_add);
    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    hazard   = ex_valid && ex_mem_read && (ex_dest != '0) && id_valid && (rs_match || rt_match);
    // A taken branch kills the decode slot anyway, so holding it would be pointless.
    stall    = hazard && !ex_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubbles, plus a saturating
// count of inserted bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned WIDTH_ADD = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [WIDTH-1:0]     id_pc,
  input  logic [WIDTH_ADD-1:0] rs_add,
  input  logic [WIDTH_ADD-1:0] rt_add,
  input  logic [WIDTH_ADD-1:0] rd_add,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [15:0]          imm16,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 ex_flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [WIDTH-1:0]     ex_pc,
  output logic [WIDTH-1:0]     ex_rs_data,
  output logic [WIDTH-1:0]     ex_rt_data,
  output logic [WIDTH-1:0]     ex_imm,
  output logic [WIDTH_ADD-1:0] ex_rs_add,
  output logic [WIDTH_ADD-1:0] ex_rt_add,
  output logic [WIDTH_ADD-1:0] ex_dest,
  output logic [15:0]          bubble_count
);

  logic                 hazard;
  logic                 hazard_stall;
  logic                 load_bubble;
  logic [WIDTH-1:0]     imm_ext;
  logic [WIDTH_ADD-1:0] id_dest;

  logic                 valid_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     rs_data_q;
  logic [WIDTH-1:0]     rt_data_q;
  logic [WIDTH-1:0]     imm_q;
  logic [WIDTH_ADD-1:0] rs_add_q;
  logic [WIDTH_ADD-1:0] rt_add_q;
  logic [WIDTH_ADD-1:0] dest_q;
  logic [15:0]          count_q;

  hazard_unit #(
    .WIDTH_ADD (WIDTH_ADD)
  ) u_hazard_unit (
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q[CTRL_MEM_READ]),
    .ex_dest      (dest_q),
    .id_valid     (id_valid),
    .id_alu_src   (id_ctrl[CTRL_ALU_SRC]),
    .id_mem_write (id_ctrl[CTRL_MEM_WRITE]),
    .rs_add       (rs_add),
    .rt_add       (rt_add),
    .ex_flush     (ex_flush),
    .hazard       (hazard),
    .stall        (hazard_stall)
  );

  always_comb begin
    imm_ext     = {{(WIDTH-16){imm16[15]}}, imm16};
    id_dest     = id_ctrl[CTRL_REG_DST] ? rd_add : rt_add;
    // Hold the front end quiet while reset is asserted; EX contents are not yet meaningful.
    stall       = hazard_stall && !reset;
    load_bubble = ex_flush || hazard_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_add_q  <= '0;
      rt_add_q  <= '0;
      dest_q    <= '0;
      count_q   <= '0;
    end else if (load_bubble) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_add_q  <= '0;
      rt_add_q  <= '0;
      dest_q    <= '0;
      if (count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
    end else begin
      valid_q   <= id_valid;
      ctrl_q    <= id_valid ? id_ctrl : '0;
      pc_q      <= id_pc;
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
      imm_q     <= imm_ext;
      rs_add_q  <= rs_add;
      rt_add_q  <= rt_add;
      dest_q    <= id_dest;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_pc        = pc_q;
  assign ex_rs_data   = rs_data_q;
  assign ex_rt_data   = rt_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs_add    = rs_add_q;
  assign ex_rt_add    = rt_add_q;
  assign ex_dest      = dest_q;
  assign bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage: load-use stalls, flush priority,
// immediate extension, bubble counter saturation and reset override.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  rs_add, rt_add, rd_add;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm16;
  logic [7:0]  id_ctrl;
  logic        ex_flush;
  logic        stall;
  logic        ex_valid;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs_add, ex_rt_add, ex_dest;
  logic [15:0] bubble_count;

  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage #(
    .WIDTH     (32),
    .WIDTH_ADD (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .rs_add       (rs_add),
    .rt_add       (rt_add),
    .rd_add       (rd_add),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .imm16        (imm16),
    .id_ctrl      (id_ctrl),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_ctrl      (ex_ctrl),
    .ex_pc        (ex_pc),
    .ex_rs_data   (ex_rs_data),
    .ex_rt_data   (ex_rt_data),
    .ex_imm       (ex_imm),
    .ex_rs_add    (ex_rs_add),
    .ex_rt_add    (ex_rt_add),
    .ex_dest      (ex_dest),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  ctrl;
    logic [15:0] imm;
    logic        flush;
    logic [31:0] pc;
    logic        e_stall;
    logic        e_bub;
    logic [31:0] e_imm;
    logic [4:0]  e_dest;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [7:0] ctrl,
                              input logic [15:0] imm, input logic flush, input logic [31:0] pc,
                              input logic e_stall, input logic e_bub, input logic [31:0] e_imm,
                              input logic [4:0] e_dest, input logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.ctrl = ctrl; r.imm = imm; r.flush = flush;
    r.pc = pc; r.e_stall = e_stall; r.e_bub = e_bub; r.e_imm = e_imm; r.e_dest = e_dest;
    r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, ".ex_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
    chk({tag, ".ex_pc"}, ex_pc, 32'd0);
    chk({tag, ".ex_rs_data"}, ex_rs_data, 32'd0);
    chk({tag, ".ex_rt_data"}, ex_rt_data, 32'd0);
    chk({tag, ".ex_imm"}, ex_imm, 32'd0);
    chk({tag, ".ex_addrs"}, {17'd0, ex_rs_add, ex_rt_add, ex_dest}, 32'd0);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".bubble_count"}, {16'd0, bubble_count}, 32'd0);
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.v;
    rs_add   = r.rs;
    rt_add   = r.rt;
    rd_add   = r.rd;
    id_ctrl  = r.ctrl;
    imm16    = r.imm;
    ex_flush = r.flush;
    id_pc    = r.pc;
    rs_data  = r.pc + 32'h1000;
    rt_data  = r.pc + 32'h2000;
  endtask

  initial begin
    string tag;
    // Reset for two cycles with random decode inputs, including random flush.
    reset    = 1'b1;
    id_valid = 1'($urandom);
    id_pc    = $urandom;
    rs_add   = 5'($urandom);
    rt_add   = 5'($urandom);
    rd_add   = 5'($urandom);
    rs_data  = $urandom;
    rt_data  = $urandom;
    imm16    = 16'($urandom);
    id_ctrl  = 8'($urandom);
    ex_flush = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    //          v  rs  rt  rd  ctrl   imm       fl pc       stl bub e_imm         dst cnt
    tbl[0]  = mk(1, 1,  8,  0,  8'h68, 16'h0004, 0, 32'h100, 0,  0,  32'h4,        8,  0); // lw $8
    tbl[1]  = mk(1, 8,  9,  10, 8'h84, 16'h0010, 0, 32'h104, 1,  1,  32'h0,        0,  1); // add uses $8
    tbl[2]  = mk(1, 8,  9,  10, 8'h84, 16'h0010, 0, 32'h104, 0,  0,  32'h10,       10, 1); // re-presented
    tbl[3]  = mk(1, 2,  8,  0,  8'h68, 16'h0000, 0, 32'h108, 0,  0,  32'h0,        8,  1); // lw $8
    tbl[4]  = mk(1, 3,  8,  0,  8'h88, 16'h0005, 0, 32'h10c, 0,  0,  32'h5,        8,  1); // addi rt=8
    tbl[5]  = mk(1, 4,  0,  0,  8'h68, 16'hffff, 0, 32'h110, 0,  0,  32'hffffffff, 0,  1); // lw $0
    tbl[6]  = mk(1, 0,  0,  5,  8'h84, 16'h0000, 0, 32'h114, 0,  0,  32'h0,        5,  1); // uses $0
    tbl[7]  = mk(1, 6,  8,  0,  8'h68, 16'h0000, 0, 32'h118, 0,  0,  32'h0,        8,  1); // lw $8
    tbl[8]  = mk(1, 1,  8,  0,  8'h18, 16'h0008, 0, 32'h11c, 1,  1,  32'h0,        0,  2); // sw rt=8
    tbl[9]  = mk(1, 1,  8,  0,  8'h18, 16'h0008, 0, 32'h11c, 0,  0,  32'h8,        8,  2);
    tbl[10] = mk(1, 7,  8,  0,  8'h68, 16'h0000, 0, 32'h120, 0,  0,  32'h0,        8,  2); // lw $8
    tbl[11] = mk(1, 8,  9,  10, 8'h84, 16'h0000, 1, 32'h124, 0,  1,  32'h0,        0,  3); // hazard+flush
    tbl[12] = mk(1, 8,  3,  0,  8'h88, 16'h8001, 0, 32'h128, 0,  0,  32'hffff8001, 3,  3);
    tbl[13] = mk(0, 0,  0,  0,  8'h84, 16'h0000, 0, 32'h12c, 0,  0,  32'h0,        0,  3); // empty slot
    tbl[14] = mk(1, 2,  8,  0,  8'h68, 16'h7fff, 0, 32'h130, 0,  0,  32'h00007fff, 8,  3); // lw $8
    tbl[15] = mk(0, 8,  0,  0,  8'h00, 16'h0000, 0, 32'h134, 0,  0,  32'h0,        0,  3); // invalid rs=8

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      tag = $sformatf("row%0d", i);
      @(negedge clk);
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, tbl[i].e_stall});
      @(posedge clk);
      #1;
      if (tbl[i].e_bub) begin
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, ".ex_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
        chk({tag, ".ex_pc"}, ex_pc, 32'd0);
        chk({tag, ".ex_rs_data"}, ex_rs_data, 32'd0);
        chk({tag, ".ex_rs_add"}, {27'd0, ex_rs_add}, 32'd0);
      end else begin
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, tbl[i].v});
        chk({tag, ".ex_ctrl"}, {24'd0, ex_ctrl}, tbl[i].v ? {24'd0, tbl[i].ctrl} : 32'd0);
        chk({tag, ".ex_pc"}, ex_pc, tbl[i].pc);
        chk({tag, ".ex_rs_data"}, ex_rs_data, tbl[i].pc + 32'h1000);
        chk({tag, ".ex_rs_add"}, {27'd0, ex_rs_add}, {27'd0, tbl[i].rs});
      end
      chk({tag, ".ex_rt_data"}, ex_rt_data, tbl[i].e_bub ? 32'd0 : tbl[i].pc + 32'h2000);
      chk({tag, ".ex_imm"}, ex_imm, tbl[i].e_imm);
      chk({tag, ".ex_dest"}, {27'd0, ex_dest}, {27'd0, tbl[i].e_dest});
      chk({tag, ".bubble_count"}, {16'd0, bubble_count}, {16'd0, tbl[i].e_cnt});
    end

    // Long flush run: counter climbs from 3 and must pin at all-ones.
    id_valid = 1'b1;
    ex_flush = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat.bubble_count", {16'd0, bubble_count}, 32'h0000ffff);
    chk("sat.ex_valid", {31'd0, ex_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("sat.hold", {16'd0, bubble_count}, 32'h0000ffff);

    // Put a load in EX, then assert reset while a dependent instruction sits in decode.
    drive(mk(1, 1, 8, 0, 8'h68, 16'h0001, 0, 32'h200, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre_rst.ex_ctrl", {24'd0, ex_ctrl}, 32'h68);
    drive(mk(1, 8, 9, 10, 8'h84, 16'h0002, 0, 32'h204, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("pre_rst.stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("in_rst.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk_all_zero("rst_override");
    // Reset also beats a flush.
    ex_flush = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("rst_flush");
    reset    = 1'b0;
    ex_flush = 1'b0;
    @(negedge clk);
    chk("post_rst.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst.ex_ctrl", {24'd0, ex_ctrl}, 32'h84);
    chk("post_rst.ex_dest", {27'd0, ex_dest}, 32'd10);
    chk("post_rst.bubble_count", {16'd0, bubble_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
